// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Parametrised chain of elastic register stages that carries a packed
//   control+data bundle between datapath stages. Each stage has a main register
//   and, when SKID=1, a skid register. With SKID=1 the ready signals are
//   registered. With SKID=0 there is no skid register and ready ripples
//   combinationally from the output end of the chain.
//
// Ports
//   Clk        in   1        clock, rising edge
//   Rst        in   1        asynchronous active-low reset
//   InValid    in   1        upstream word valid
//   InReady    out  1        chain accepts a word this cycle
//   InData     in   WIDTH    upstream payload
//   OutValid   out  1        last-stage word valid
//   OutReady   in   1        downstream accepts (0 = stall)
//   OutData    out  WIDTH    last-stage main register
//   Flush      in   STAGES   bit k kills all content of stage k (bit 0 = input side)
//   StageValid out  STAGES   bit k = main valid of stage k
//   Count      out  CW       total valid entries (main + skid) over all stages

module pipe_stage_chain #(
    parameter int              WIDTH      = 32,
    parameter int              STAGES     = 4,
    parameter int              SKID       = 1,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic                              InValid,
    output logic                              InReady,
    input  logic [WIDTH-1:0]                  InData,
    output logic                              OutValid,
    input  logic                              OutReady,
    output logic [WIDTH-1:0]                  OutData,
    input  logic [STAGES-1:0]                 Flush,
    output logic [STAGES-1:0]                 StageValid,
    output logic [$clog2(2*STAGES+1)-1:0]     Count
);

    localparam int CW = $clog2(2*STAGES+1);

    logic [STAGES-1:0] mainValid, skidValid;
    logic [STAGES-1:0] mainValidNxt, skidValidNxt;
    logic [STAGES-1:0] loadMainIn, loadMainSkid, loadSkid;
    logic [STAGES-1:0] take, leave;
    logic [WIDTH-1:0]  mainData [STAGES];
    logic [WIDTH-1:0]  skidData [STAGES];
    logic [CW-1:0]     countNxt;

    // Index k of these chains is the input side of stage k; index STAGES is
    // the chain output, so stage k's downstream ready is readyChain[k+1].
    logic [STAGES:0]   readyChain;
    logic [STAGES:0]   validChain;
    logic [WIDTH-1:0]  dataChain [STAGES+1];

    always_comb begin : readyPath
        readyChain[STAGES] = OutReady;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (SKID != 0)
                readyChain[k] = ~skidValid[k];
            else
                readyChain[k] = ~mainValid[k] | readyChain[k+1];
        end
    end

    assign validChain = {mainValid, InValid};

    always_comb begin : dataPath
        dataChain[0] = InData;
        for (int k = 0; k < STAGES; k++)
            dataChain[k+1] = mainData[k];
    end

    assign take  = validChain[STAGES-1:0] & readyChain[STAGES-1:0];
    assign leave = mainValid & readyChain[STAGES:1];

    always_comb begin : nextState
        mainValidNxt = mainValid;
        skidValidNxt = skidValid;
        loadMainIn   = '0;
        loadMainSkid = '0;
        loadSkid     = '0;
        countNxt     = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (!mainValid[k] || leave[k]) begin
                // A parked skid word is older than anything arriving, so it
                // takes the main slot first and the arrival refills the skid.
                if (SKID != 0 && skidValid[k]) begin
                    mainValidNxt[k] = 1'b1;
                    loadMainSkid[k] = 1'b1;
                    skidValidNxt[k] = take[k];
                    loadSkid[k]     = take[k];
                end else begin
                    mainValidNxt[k] = take[k];
                    loadMainIn[k]   = take[k];
                end
            end else if (SKID != 0 && take[k]) begin
                skidValidNxt[k] = 1'b1;
                loadSkid[k]     = 1'b1;
            end
            // Flush only kills valids: the upstream handshake still completes
            // and a word leaving this stage on the same edge is still delivered.
            if (Flush[k]) begin
                mainValidNxt[k] = 1'b0;
                skidValidNxt[k] = 1'b0;
            end
            countNxt = countNxt + CW'(mainValidNxt[k]) + CW'(skidValidNxt[k]);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mainValid <= '0;
            skidValid <= '0;
            Count     <= '0;
            for (int k = 0; k < STAGES; k++) begin
                mainData[k] <= RESET_DATA;
                skidData[k] <= RESET_DATA;
            end
        end else begin
            mainValid <= mainValidNxt;
            skidValid <= skidValidNxt;
            Count     <= countNxt;
            for (int k = 0; k < STAGES; k++) begin
                if (loadMainSkid[k])
                    mainData[k] <= skidData[k];
                else if (loadMainIn[k])
                    mainData[k] <= dataChain[k];
                if (loadSkid[k])
                    skidData[k] <= dataChain[k];
            end
        end
    end

    assign InReady    = readyChain[0];
    assign OutValid   = validChain[STAGES];
    assign OutData    = dataChain[STAGES];
    assign StageValid = mainValid;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain
//   Drives a skid-buffered chain (dut) and a no-skid chain (dutNs) of four
//   32-bit stages. Each chain is checked against a word queue holding the
//   words that were accepted and not yet delivered, in FIFO order.

module tb_pipe_stage_chain;

    localparam int W = 32;
    localparam int N = 4;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;

    logic         InValid = 1'b0, OutReady = 1'b1;
    logic [W-1:0] InData = '0;
    logic [N-1:0] Flush = '0;
    logic         InReady, OutValid;
    logic [W-1:0] OutData;
    logic [N-1:0] StageValid;
    logic [3:0]   Count;

    logic         InValidNs = 1'b0, OutReadyNs = 1'b1;
    logic [W-1:0] InDataNs = '0;
    logic [N-1:0] FlushNs = '0;
    logic         InReadyNs, OutValidNs;
    logic [W-1:0] OutDataNs;
    logic [N-1:0] StageValidNs;
    logic [3:0]   CountNs;

    pipe_stage_chain #(.WIDTH(W), .STAGES(N), .SKID(1), .RESET_DATA('0)) dut (
        .Clk(Clk), .Rst(Rst),
        .InValid(InValid), .InReady(InReady), .InData(InData),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .Flush(Flush), .StageValid(StageValid), .Count(Count)
    );

    pipe_stage_chain #(.WIDTH(W), .STAGES(N), .SKID(0), .RESET_DATA('0)) dutNs (
        .Clk(Clk), .Rst(Rst),
        .InValid(InValidNs), .InReady(InReadyNs), .InData(InDataNs),
        .OutValid(OutValidNs), .OutReady(OutReadyNs), .OutData(OutDataNs),
        .Flush(FlushNs), .StageValid(StageValidNs), .Count(CountNs)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] qNs[$];
    int  rmIdx = -1, rmCnt = 0, rmIdxNs = -1, rmCntNs = 0;
    bit  dropIn = 0;
    bit  lastAcc = 0, lastAccNs = 0;
    int  firstOutCyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: sample handshakes before the edge, update the queues after it.
    task automatic tick();
        logic acc, oxf, accNs, oxfNs;
        logic [W-1:0] din, dout, dinNs, doutNs;
        #1;
        acc    = InValid & InReady;     oxf    = OutValid & OutReady;
        din    = InData;                dout   = OutData;
        accNs  = InValidNs & InReadyNs; oxfNs  = OutValidNs & OutReadyNs;
        dinNs  = InDataNs;              doutNs = OutDataNs;
        if (q.size() == 0)   check("outvalid_when_empty", 32'(OutValid), 32'(0));
        if (qNs.size() == 0) check("ns_outvalid_when_empty", 32'(OutValidNs), 32'(0));
        @(posedge Clk);
        #1;
        cyc++;
        if (oxf && q.size() > 0)     check("out_data", dout, q.pop_front());
        if (oxfNs && qNs.size() > 0) check("ns_out_data", doutNs, qNs.pop_front());
        if (acc && !dropIn) q.push_back(din);
        if (accNs) qNs.push_back(dinNs);
        if (rmIdx >= 0) begin
            for (int i = 0; i < rmCnt; i++) if (rmIdx < q.size()) q.delete(rmIdx);
            rmIdx = -1;
        end
        if (rmIdxNs >= 0) begin
            for (int i = 0; i < rmCntNs; i++) if (rmIdxNs < qNs.size()) qNs.delete(rmIdxNs);
            rmIdxNs = -1;
        end
        dropIn = 0;
        check("count", 32'(Count), 32'(q.size()));
        check("ns_count", 32'(CountNs), 32'(qNs.size()));
        if (OutValid && firstOutCyc < 0) firstOutCyc = cyc;
        lastAcc   = acc;
        lastAccNs = accNs;
    endtask

    initial begin
        int word, presentCyc;

        // reset state
        #2;
        check("rst_inready", 32'(InReady), 32'(1));
        check("rst_outvalid", 32'(OutValid), 32'(0));
        check("rst_count", 32'(Count), 32'(0));
        check("rst_outdata", OutData, 32'h0);
        check("rst_stagevalid", 32'(StageValid), 32'(0));
        check("ns_rst_inready", 32'(InReadyNs), 32'(1));
        @(negedge Clk); Rst = 1'b1;
        @(posedge Clk); #1;

        // back-to-back stream, no back-pressure: latency and steady occupancy
        firstOutCyc = -1;
        presentCyc  = -1;
        OutReady = 1'b1;
        InValid  = 1'b1;
        word = 1;
        for (int i = 0; i < 30 && word <= 10; i++) begin
            InData = 32'(word);
            if (word == 1) presentCyc = cyc;
            tick();
            if (lastAcc) word++;
            if (i == 5) check("t2_count_steady", 32'(Count), 32'(4));
        end
        InValid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t2_latency", 32'(firstOutCyc - presentCyc), 32'(N));
        check("t2_drained", 32'(Count), 32'(0));

        // stall fills main+skid of every stage, then release with no gap
        OutReady = 1'b0;
        InValid  = 1'b1;
        word = 'h10;
        for (int i = 0; i < 16; i++) begin
            InData = 32'(word);
            tick();
            if (lastAcc) word++;
        end
        check("t3_accepted", 32'(word - 'h10), 32'(8));
        check("t3_count_full", 32'(Count), 32'(8));
        check("t3_inready_full", 32'(InReady), 32'(0));
        OutReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            InValid = (word <= 'h1F);
            InData  = 32'(word);
            if (i < 8) check("t3_nogap", 32'(OutValid), 32'(1));
            tick();
            if (lastAcc) word++;
        end
        InValid = 1'b0;
        check("t3_drained", 32'(Count), 32'(0));

        // flush the middle of a completely full skid chain: stage 2 holds 0x22,0x23
        OutReady = 1'b0;
        InValid  = 1'b1;
        word = 'h20;
        for (int i = 0; i < 16; i++) begin
            InValid = (word <= 'h27);
            InData  = 32'(word);
            tick();
            if (lastAcc) word++;
        end
        InValid = 1'b0;
        check("t4s_count_full", 32'(Count), 32'(8));
        check("t4s_stagevalid_full", 32'(StageValid), 32'(4'b1111));
        Flush = 4'b0100;
        rmIdx = 2; rmCnt = 2;
        tick();
        Flush = '0;
        check("t4s_count_flush", 32'(Count), 32'(6));
        check("t4s_stagevalid_flush", 32'(StageValid), 32'(4'b1011));
        OutReady = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("t4s_drained", 32'(Count), 32'(0));

        // flush of the input stage swallows the word accepted on the same edge
        InValid = 1'b1;
        InData  = 32'h55;
        Flush   = 4'b0001;
        dropIn  = 1;
        tick();
        Flush   = '0;
        InValid = 1'b0;
        check("t5_accepted", 32'(lastAcc), 32'(1));
        check("t5_stagevalid", 32'(StageValid), 32'(0));
        for (int i = 0; i < 8; i++) tick();

        // no-skid chain holding 0xA,0xB,0xC,0xD (stage3..0) under stall; flush stage 2
        OutReadyNs = 1'b0;
        InValidNs  = 1'b1;
        word = 'hA;
        for (int i = 0; i < 10; i++) begin
            InValidNs = (word <= 'hD);
            InDataNs  = 32'(word);
            tick();
            if (lastAccNs) word++;
        end
        InValidNs = 1'b0;
        check("t4_count_full", 32'(CountNs), 32'(4));
        check("t4_stagevalid_full", 32'(StageValidNs), 32'(4'b1111));
        FlushNs = 4'b0100;
        rmIdxNs = 1; rmCntNs = 1;
        tick();
        FlushNs = '0;
        check("t4_count_flush", 32'(CountNs), 32'(3));
        check("t4_stagevalid_flush", 32'(StageValidNs), 32'(4'b1011));
        OutReadyNs = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("t4_drained", 32'(CountNs), 32'(0));

        // no-skid chain under stall: capacity 4, combinational ready
        OutReadyNs = 1'b0;
        InValidNs  = 1'b1;
        word = 'h10;
        for (int i = 0; i < 10; i++) begin
            InDataNs = 32'(word);
            tick();
            if (lastAccNs) word++;
        end
        check("t6_accepted", 32'(word - 'h10), 32'(4));
        check("t6_count_full", 32'(CountNs), 32'(4));
        check("t6_inready_full", 32'(InReadyNs), 32'(0));
        OutReadyNs = 1'b1;
        #1;
        check("t6_inready_release", 32'(InReadyNs), 32'(1));
        OutReadyNs = 1'b0;
        #1;
        check("t6_inready_stall", 32'(InReadyNs), 32'(0));
        OutReadyNs = 1'b1;
        for (int i = 0; i < 30; i++) begin
            InValidNs = (word <= 'h1F);
            InDataNs  = 32'(word);
            tick();
            if (lastAccNs) word++;
        end
        InValidNs = 1'b0;
        check("t6_drained", 32'(CountNs), 32'(0));

        // asynchronous reset in the middle of a stream
        InValid = 1'b1; OutReady = 1'b1; InValidNs = 1'b1; OutReadyNs = 1'b1;
        for (int i = 0; i < 6; i++) begin
            InData   = $urandom;
            InDataNs = $urandom;
            tick();
        end
        #2;
        Rst = 1'b0;
        #1;
        check("t1_outvalid", 32'(OutValid), 32'(0));
        check("t1_count", 32'(Count), 32'(0));
        check("t1_inready", 32'(InReady), 32'(1));
        check("t1_outdata", OutData, 32'h0);
        check("t1_stagevalid", 32'(StageValid), 32'(0));
        check("t1_ns_count", 32'(CountNs), 32'(0));
        check("t1_ns_outvalid", 32'(OutValidNs), 32'(0));
        q.delete();
        qNs.delete();
        InValid = 1'b0; InValidNs = 1'b0;
        @(negedge Clk); Rst = 1'b1;
        @(posedge Clk); #1;

        // random traffic on both chains
        for (int i = 0; i < 400; i++) begin
            InValid    = ($urandom_range(0, 9) < 7);
            InData     = $urandom;
            OutReady   = ($urandom_range(0, 9) < 6);
            InValidNs  = ($urandom_range(0, 9) < 7);
            InDataNs   = $urandom;
            OutReadyNs = ($urandom_range(0, 9) < 6);
            #1;
            if (q.size() == 2 * N) check("rand_full_inready", 32'(InReady), 32'(0));
            if (qNs.size() == N && !OutReadyNs) check("rand_ns_full_inready", 32'(InReadyNs), 32'(0));
            tick();
        end
        InValid = 1'b0; OutReady = 1'b1; InValidNs = 1'b0; OutReadyNs = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("final_count", 32'(Count), 32'(0));
        check("final_ns_count", 32'(CountNs), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
